// File: rtl/bus_source_arbiter_if.sv
// Bus-drive request/grant bundle shared by the source arbiter and its requesters.
// The arbiter uses the slave modport; requesters or a testbench use master.
interface bus_source_arbiter_if #(
    parameter int N_SRC = 32,
    parameter int PTR_W = 5
);
    logic [N_SRC-1:0] req_in;
    logic [N_SRC-1:0] grant_out;
    logic [PTR_W-1:0] grant_idx;
    logic             grant_valid;
    logic             hold_expired;

    modport master (
        output req_in,
        input  grant_out,
        input  grant_idx,
        input  grant_valid,
        input  hold_expired
    );

    modport slave (
        input  req_in,
        output grant_out,
        output grant_idx,
        output grant_valid,
        output hold_expired
    );
endinterface

// File: rtl/bus_source_arbiter.sv
// Round-robin arbiter feeding the 32-to-5 bus encoder. It issues a registered one-hot
// grant and limits each source's tenure to MAX_HOLD cycles while other sources wait.
module bus_source_arbiter #(
    parameter int N_SRC    = 32,
    parameter int PTR_W    = 5,
    parameter int MAX_HOLD = 4
) (
    input logic                 clk,
    input logic                 clr,
    bus_source_arbiter_if.slave bus
);
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]        state_q,    state_d;
    logic [N_SRC-1:0]  grant_q,    grant_d;
    logic [PTR_W-1:0]  idx_q,      idx_d;
    logic [PTR_W-1:0]  last_ptr_q, last_ptr_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              expired_q,  expired_d;

    logic [N_SRC-1:0]  others;
    logic              found;
    logic [PTR_W-1:0]  win_idx;
    logic [PTR_W-1:0]  cand;
    logic              holder_req;

    // The holder is always last_ptr, so masking it out and scanning from last_ptr+1
    // leaves the holder as the final candidate in the round-robin order.
    always_comb begin
        others  = bus.req_in & ~grant_q;
        found   = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int unsigned i = 1; i <= N_SRC; i++) begin
            cand = PTR_W'((32'(last_ptr_q) + i) % 32'(N_SRC));
            if (!found && others[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end

    assign holder_req = |(bus.req_in & grant_q);

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        idx_d      = idx_q;
        last_ptr_d = last_ptr_q;
        hold_cnt_d = hold_cnt_q;
        expired_d  = 1'b0;
        if (state_q == IDLE || !holder_req || hold_cnt_q == HOLD_MAX) begin
            if (found) begin
                state_d    = GRANT;
                grant_d    = N_SRC'(1) << win_idx;
                idx_d      = win_idx;
                last_ptr_d = win_idx;
                hold_cnt_d = HOLD_ONE;
                expired_d  = (state_q == GRANT) && holder_req;
            end else if (state_q == GRANT && holder_req) begin
                hold_cnt_d = HOLD_ONE;
            end else begin
                state_d    = IDLE;
                grant_d    = '0;
                idx_d      = '0;
                hold_cnt_d = '0;
            end
        end else begin
            hold_cnt_d = hold_cnt_q + HOLD_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            idx_q      <= '0;
            last_ptr_q <= PTR_W'(N_SRC - 1);
            hold_cnt_q <= '0;
            expired_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            idx_q      <= idx_d;
            last_ptr_q <= last_ptr_d;
            hold_cnt_q <= hold_cnt_d;
            expired_q  <= expired_d;
        end
    end

    assign bus.grant_out    = grant_q;
    assign bus.grant_idx    = idx_q;
    assign bus.grant_valid  = |grant_q;
    assign bus.hold_expired = expired_q;
endmodule

// File: tb/tb_bus_source_arbiter.sv
// Scoreboard bench for bus_source_arbiter: a rule-level model predicts each cycle's
// outputs at stimulus time, and an independent monitor compares them after each edge.
module tb_bus_source_arbiter;
    localparam int N   = 32;
    localparam int PW  = 5;
    localparam int MH  = 4;

    typedef struct {
        logic [N-1:0]  g;
        logic [PW-1:0] idx;
        logic          v;
        logic          he;
    } exp_t;

    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    bus_source_arbiter_if #(.N_SRC(N), .PTR_W(PW)) bus ();

    bus_source_arbiter #(.N_SRC(N), .PTR_W(PW), .MAX_HOLD(MH)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    // Model state: who holds the bus (-1 = nobody), last winner, cycles held.
    int m_holder = -1;
    int m_last   = N - 1;
    int m_cnt    = 0;

    function automatic int rr_pick(input logic [N-1:0] r, input int from);
        for (int k = 1; k <= N; k++) begin
            int s;
            s = (from + k) % N;
            if (r[s]) return s;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [N-1:0] r, input logic c, output exp_t e);
        logic          cut;
        logic [N-1:0]  rest;
        int            w;
        cut = 1'b0;
        if (c) begin
            m_holder = -1;
            m_last   = N - 1;
            m_cnt    = 0;
        end else if (m_holder < 0) begin
            w = rr_pick(r, m_last);
            if (w >= 0) begin m_holder = w; m_last = w; m_cnt = 1; end
        end else begin
            rest = r;
            rest[m_holder] = 1'b0;
            w = rr_pick(rest, m_holder);
            if (!r[m_holder]) begin
                if (w >= 0) begin m_holder = w; m_last = w; m_cnt = 1; end
                else m_holder = -1;
            end else if (m_cnt < MH) begin
                m_cnt++;
            end else if (w >= 0) begin
                m_holder = w; m_last = w; m_cnt = 1; cut = 1'b1;
            end else begin
                m_cnt = 1;
            end
        end
        e.g   = '0;
        e.idx = '0;
        e.v   = (m_holder >= 0);
        e.he  = cut;
        if (m_holder >= 0) begin
            e.g[m_holder] = 1'b1;
            e.idx = PW'(m_holder);
        end
    endtask

    task automatic drive(input logic [N-1:0] r, input logic c);
        exp_t e;
        @(negedge clk);
        bus.req_in = r;
        clr        = c;
        model_step(r, c, e);
        exp_q.push_back(e);
    endtask

    task automatic hold(input logic [N-1:0] r, input int n);
        for (int k = 0; k < n; k++) drive(r, 1'b0);
    endtask

    // Monitor: every cycle that has a prediction outstanding, compare all outputs.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (bus.grant_out !== e.g) begin
                    failures++;
                    $display("FAIL grant_out cyc=%0d actual=%h required=%h", cyc, bus.grant_out, e.g);
                end
                checks++;
                if (bus.grant_idx !== e.idx) begin
                    failures++;
                    $display("FAIL grant_idx cyc=%0d actual=%0d required=%0d", cyc, bus.grant_idx, e.idx);
                end
                checks++;
                if (bus.grant_valid !== e.v) begin
                    failures++;
                    $display("FAIL grant_valid cyc=%0d actual=%b required=%b", cyc, bus.grant_valid, e.v);
                end
                checks++;
                if (bus.hold_expired !== e.he) begin
                    failures++;
                    $display("FAIL hold_expired cyc=%0d actual=%b required=%b", cyc, bus.hold_expired, e.he);
                end
            end
        end
    end

    initial begin
        logic [N-1:0] r;
        int           sel;
        bus.req_in = '0;
        clr        = 1'b1;

        // Reset state, then a single low-order request.
        drive('0, 1'b1);
        drive('0, 1'b1);
        drive(32'h0000_0001, 1'b0);
        drive('0, 1'b0);

        // Two sources held from IDLE: 4-cycle tenures with a cut pulse at each switch.
        drive('0, 1'b1);
        hold(32'h0010_0008, 12);
        drive('0, 1'b0);

        // Grant 31, go idle, then 31 and 2 together must wrap to 2.
        hold(32'h8000_0000, 2);
        drive('0, 1'b0);
        hold(32'h8000_0004, 3);
        drive('0, 1'b0);

        // A lone requester keeps the bus with no cut pulse.
        hold(32'h0020_0000, 10);

        // Holder 5 drops while 9 raises: handover with no idle gap.
        drive('0, 1'b0);
        hold(32'h0000_0020, 2);
        hold(32'h0000_0200, 3);

        // Reset mid-tenure with everything pending, then all-ones restarts at 0.
        hold(32'hFFFF_FFFF, 3);
        drive(32'hFFFF_FFFF, 1'b1);
        hold(32'hFFFF_FFFF, 10);
        drive('0, 1'b0);

        // Randomized traffic: held patterns, sparse patterns, single bits, idle, resets.
        r = '0;
        for (int k = 0; k < 600; k++) begin
            sel = int'($urandom_range(0, 9));
            if (sel == 6 || sel == 7) r = $urandom & $urandom & $urandom;
            else if (sel == 8) r = N'(1) << $urandom_range(0, N - 1);
            else if (sel == 9) r = '0;
            drive(r, ($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0);
        end
        drive('0, 1'b0);

        @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
